// File: rtl/vector_activation_pkg.sv
// vector_activation_pkg: activation mode encodings, FSM states and clog2 helper.
package vector_activation_pkg;

    typedef enum logic [1:0] {
        ACT_IDENTITY = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_LEAKY    = 2'd2,
        ACT_SIGMOID  = 2'd3
    } act_mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/sigmoid_approx.sv
// sigmoid_approx: piecewise-linear sigmoid in signed Q(Q_FRAC) fixed point, odd-symmetric about 0.5.
module sigmoid_approx #(
    parameter int DATA_WIDTH = 16,
    parameter int Q_FRAC     = 8
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);
    localparam int W = DATA_WIDTH + 1;
    localparam logic signed [W-1:0] ONE = W'(1 << Q_FRAC);
    localparam logic signed [W-1:0] T5  = W'(5 << Q_FRAC);
    localparam logic signed [W-1:0] T2  = W'(19 << (Q_FRAC - 3));
    localparam logic signed [W-1:0] C2  = W'(27 << (Q_FRAC - 5));
    localparam logic signed [W-1:0] C1  = W'(5 << (Q_FRAC - 3));
    localparam logic signed [W-1:0] C0  = W'(1 << (Q_FRAC - 1));

    logic signed [W-1:0] ax, pos;

    // Evaluate on |x| with one spare bit so the most negative input folds safely.
    always_comb begin
        ax  = x[DATA_WIDTH-1] ? -W'(x) : W'(x);
        pos = ax >= T5  ? ONE :
              ax >= T2  ? (ax >>> 5) + C2 :
              ax >= ONE ? (ax >>> 3) + C1 :
                          (ax >>> 2) + C0;
        y   = DATA_WIDTH'(x[DATA_WIDTH-1] ? ONE - pos : pos);
    end

endmodule

// File: rtl/vector_activation_unit.sv
// activation_unit: one combinational lane (identity/ReLU/leaky ReLU/sigmoid).
// Leaky ReLU is built only with VECTOR_ACTIVATION_LEAKY_EN; otherwise mode 2 acts as ReLU.
module activation_unit
    import vector_activation_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int Q_FRAC      = 8,
    parameter int LEAKY_SHIFT = 3
) (
    input  act_mode_e                    mode,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);
    logic signed [DATA_WIDTH-1:0] sig, relu, leaky;

    sigmoid_approx #(.DATA_WIDTH(DATA_WIDTH), .Q_FRAC(Q_FRAC)) u_sig (.x(x), .y(sig));

    always_comb begin
        relu  = x[DATA_WIDTH-1] ? '0 : x;
`ifdef VECTOR_ACTIVATION_LEAKY_EN
        leaky = x[DATA_WIDTH-1] ? x >>> LEAKY_SHIFT : x;
`else
        leaky = relu;
`endif
        y     = mode == ACT_IDENTITY ? x :
                mode == ACT_RELU     ? relu :
                mode == ACT_LEAKY    ? leaky : sig;
    end

endmodule

// File: rtl/vector_activation.sv
// vector_activation: snapshots a vector and applies an activation LANES elements per cycle.
// Optional leaky ReLU via VECTOR_ACTIVATION_LEAKY_EN (see activation_unit).
module vector_activation
    import vector_activation_pkg::*;
#(
    parameter int ELEMENT_COUNT = 128,
    parameter int DATA_WIDTH    = 16,
    parameter int Q_FRAC        = 8,
    parameter int LANES         = 4,
    parameter int LEAKY_SHIFT   = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [1:0]                          mode,
    input  logic [DATA_WIDTH*ELEMENT_COUNT-1:0] data_in,
    output logic [DATA_WIDTH*ELEMENT_COUNT-1:0] data_out,
    output logic                                busy,
    output logic                                done
);
    localparam int GROUPS = (ELEMENT_COUNT + LANES - 1) / LANES;
    localparam int GW     = clog2(GROUPS) > 0 ? clog2(GROUPS) : 1;
    localparam int LW     = DATA_WIDTH * LANES;
    localparam int PW     = LW * GROUPS;

`ifndef SYNTHESIS
    if (ELEMENT_COUNT <= 0 || LANES < 1 || LANES > ELEMENT_COUNT) begin : g_bad_cfg
        $error("vector_activation: invalid ELEMENT_COUNT/LANES combination");
    end
`endif

    state_e                          state_q, state_d;
    act_mode_e                       mode_q;
    logic [DATA_WIDTH*ELEMENT_COUNT-1:0] snap;
    logic [PW-1:0]                   in_pad, snap_pad;
    logic [LW-1:0]                   stage, act;
    logic [GW-1:0]                   grp, grp_n;
    logic                            last;

    // Zero padding makes lanes past the end of a partial last group load as zero.
    assign in_pad   = PW'(data_in);
    assign snap_pad = PW'(snap);
    assign last     = grp == GW'(GROUPS - 1);
    assign grp_n    = last ? '0 : grp + GW'(1);
    assign busy     = state_q == S_RUN;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        activation_unit #(
            .DATA_WIDTH(DATA_WIDTH), .Q_FRAC(Q_FRAC), .LEAKY_SHIFT(LEAKY_SHIFT)
        ) u_act (
            .mode(mode_q),
            .x(stage[l*DATA_WIDTH +: DATA_WIDTH]),
            .y(act[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        state_d = state_q == S_IDLE ? (start ? S_RUN : S_IDLE)
                                    : (abort || last ? S_IDLE : S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= ACT_IDENTITY;
            snap     <= '0;
            stage    <= '0;
            grp      <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= state_q == S_RUN && last && !abort;
            if (state_q == S_IDLE) begin
                if (start) begin
                    snap   <= data_in;
                    mode_q <= act_mode_e'(mode);
                    stage  <= in_pad[LW-1:0];
                    grp    <= '0;
                end
            end else begin
                // The current group's write lands even on an aborting edge.
                for (int l = 0; l < LANES; l++)
                    if (int'(grp) * LANES + l < ELEMENT_COUNT)
                        data_out[(int'(grp) * LANES + l) * DATA_WIDTH +: DATA_WIDTH] <= act[l*DATA_WIDTH +: DATA_WIDTH];
                grp   <= grp_n;
                stage <= snap_pad[int'(grp_n) * LW +: LW];
            end
        end
    end

endmodule

// File: tb/tb_vector_activation.sv
// tb_vector_activation: directed checks on three configurations (8x4, 5x2, 8x2).
module tb_vector_activation;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         rst, rst2;
    logic         st0, ab0, busy0, done0;
    logic [1:0]   md0;
    logic [127:0] din0, dout0;
    logic         st1, ab1, busy1, done1;
    logic [1:0]   md1;
    logic [79:0]  din1, dout1;
    logic         st2, ab2, busy2, done2;
    logic [1:0]   md2;
    logic [127:0] din2, dout2;

    vector_activation #(.ELEMENT_COUNT(8), .LANES(4)) u0 (
        .clk(clk), .rst(rst), .start(st0), .abort(ab0), .mode(md0),
        .data_in(din0), .data_out(dout0), .busy(busy0), .done(done0));
    vector_activation #(.ELEMENT_COUNT(5), .LANES(2)) u1 (
        .clk(clk), .rst(rst), .start(st1), .abort(ab1), .mode(md1),
        .data_in(din1), .data_out(dout1), .busy(busy1), .done(done1));
    vector_activation #(.ELEMENT_COUNT(8), .LANES(2)) u2 (
        .clk(clk), .rst(rst2), .start(st2), .abort(ab2), .mode(md2),
        .data_in(din2), .data_out(dout2), .busy(busy2), .done(done2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; rst2 = 1;
        st0 = 0; ab0 = 0; md0 = 0; din0 = '1;
        st1 = 0; ab1 = 0; md1 = 0; din1 = '1;
        st2 = 0; ab2 = 0; md2 = 0; din2 = '1;
        tick(); tick();
        checks++; if (dout0 !== 128'd0) begin errors++; $display("FAIL reset_dout0 got %h exp 0", dout0); end
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_flags0 got busy %b done %b exp 0 0", busy0, done0); end
        checks++; if (dout1 !== 80'd0) begin errors++; $display("FAIL reset_dout1 got %h exp 0", dout1); end
        checks++; if (dout2 !== 128'd0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_u2 got %h busy %b exp 0", dout2, busy2); end
        rst = 0; rst2 = 0;
        tick();
    endtask

    task automatic test_relu();
        logic [15:0] iv [8] = '{16'hFF00, 16'h0100, 16'h0000, 16'hFFFF, 16'h0200, 16'hFE00, 16'h0001, 16'h7FFF};
        logic [15:0] ev [8] = '{16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h0001, 16'h7FFF};
        for (int i = 0; i < 8; i++) din0[i*16 +: 16] = iv[i];
        md0 = 2'd1; st0 = 1;
        tick();
        st0 = 0;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL relu_busy got %b exp 1", busy0); end
        tick();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL relu_done_early got %b exp 0", done0); end
        tick();
        checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL relu_done got done %b busy %b exp 1 0", done0, busy0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dout0[i*16 +: 16] !== ev[i]) begin errors++; $display("FAIL relu_el%0d got %h exp %h", i, dout0[i*16 +: 16], ev[i]); end
        end
        tick();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL relu_done_width got %b exp 0", done0); end
    endtask

    task automatic test_identity_partial();
        din1 = {5{16'hAAAA}}; md1 = 2'd0; st1 = 1;
        tick();
        st1 = 0;
        tick(); tick(); tick();
        checks++; if (done1 !== 1'b1 || dout1 !== {5{16'hAAAA}}) begin errors++; $display("FAIL ident_prefill got done %b data %h exp 1 all AAAA", done1, dout1); end
        // start again during the done cycle: block is already idle
        for (int i = 0; i < 5; i++) din1[i*16 +: 16] = 16'(i + 1);
        st1 = 1;
        tick();
        st1 = 0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL ident_b2b_busy got %b exp 1", busy1); end
        tick(); tick();
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL ident_done_early got %b exp 0", done1); end
        tick();
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL ident_done got %b exp 1", done1); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dout1[i*16 +: 16] !== 16'(i + 1)) begin errors++; $display("FAIL ident_el%0d got %h exp %h", i, dout1[i*16 +: 16], 16'(i + 1)); end
        end
    endtask

    task automatic test_sigmoid();
        logic [16:0] sum;
        din0 = '0;
        din0[0*16 +: 16] = 16'h0000;
        din0[1*16 +: 16] = 16'h0800;
        din0[2*16 +: 16] = 16'hF800;
        din0[3*16 +: 16] = 16'h0100;
        din0[4*16 +: 16] = 16'hFF00;
        md0 = 2'd3; st0 = 1;
        tick();
        st0 = 0;
        tick(); tick();
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL sig_done got %b exp 1", done0); end
        checks++; if (dout0[15:0] !== 16'h0080) begin errors++; $display("FAIL sig_zero got %h exp 0080", dout0[15:0]); end
        checks++; if (dout0[31:16] < 16'h00FE || dout0[31:16] > 16'h0100) begin errors++; $display("FAIL sig_pos8 got %h exp 00FE..0100", dout0[31:16]); end
        checks++; if (dout0[47:32] > 16'h0002) begin errors++; $display("FAIL sig_neg8 got %h exp 0000..0002", dout0[47:32]); end
        sum = {1'b0, dout0[63:48]} + {1'b0, dout0[79:64]};
        checks++; if (sum !== 17'h00100 || dout0[63:48] <= 16'h0080) begin errors++; $display("FAIL sig_sym got %h+%h exp sum 0100 and first > 0080", dout0[63:48], dout0[79:64]); end
    endtask

    task automatic test_leaky();
        logic [15:0] ev [4];
`ifdef VECTOR_ACTIVATION_LEAKY_EN
        ev = '{16'hFFE0, 16'hFFFF, 16'h0064, 16'hFFFF};
`else
        ev = '{16'h0000, 16'h0000, 16'h0064, 16'h0000};
`endif
        din0 = '0;
        din0[0*16 +: 16] = 16'hFF00;
        din0[1*16 +: 16] = 16'hFFFF;
        din0[2*16 +: 16] = 16'h0064;
        din0[3*16 +: 16] = 16'hFFF8;
        md0 = 2'd2; st0 = 1;
        tick();
        st0 = 0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout0[i*16 +: 16] !== ev[i]) begin errors++; $display("FAIL leaky_el%0d got %h exp %h", i, dout0[i*16 +: 16], ev[i]); end
        end
    endtask

    task automatic test_snapshot();
        int dones = 0;
        logic [15:0] iv [8] = '{16'hFF00, 16'h0100, 16'hFFFF, 16'h0030, 16'h8000, 16'h0005, 16'hFFF0, 16'h0007};
        logic [15:0] ev [8] = '{16'h0000, 16'h0100, 16'h0000, 16'h0030, 16'h0000, 16'h0005, 16'h0000, 16'h0007};
        for (int i = 0; i < 8; i++) din0[i*16 +: 16] = iv[i];
        md0 = 2'd1; st0 = 1;
        tick();
        din0 = {8{16'h1234}}; md0 = 2'd0;
        tick();
        st0 = 0;
        for (int c = 0; c < 6; c++) begin
            dones += int'(done0);
            tick();
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL snap_done_count got %0d exp 1", dones); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dout0[i*16 +: 16] !== ev[i]) begin errors++; $display("FAIL snap_el%0d got %h exp %h", i, dout0[i*16 +: 16], ev[i]); end
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        din2 = {8{16'h1111}}; md2 = 2'd0; st2 = 1;
        tick();
        st2 = 0;
        tick(); tick(); tick(); tick();
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL abort_prefill_done got %b exp 1", done2); end
        for (int i = 0; i < 8; i++) din2[i*16 +: 16] = 16'(i + 1);
        st2 = 1;
        tick();
        st2 = 0;
        tick();
        ab2 = 1;
        tick();
        ab2 = 0;
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL abort_flags got busy %b done %b exp 0 0", busy2, done2); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dout2[i*16 +: 16] !== (i < 4 ? 16'(i + 1) : 16'h1111)) begin
                errors++; $display("FAIL abort_el%0d got %h exp %h", i, dout2[i*16 +: 16], (i < 4 ? 16'(i + 1) : 16'h1111));
            end
        end
        for (int c = 0; c < 4; c++) begin
            dones += int'(done2);
            tick();
        end
        checks++; if (dones != 0 || dout2[127:64] !== {4{16'h1111}}) begin errors++; $display("FAIL abort_after got dones %0d hi %h exp 0 1111..", dones, dout2[127:64]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) din2[i*16 +: 16] = 16'(i + 9);
        st2 = 1;
        tick();
        st2 = 0;
        tick();
        rst2 = 1;
        tick();
        rst2 = 0;
        checks++; if (dout2 !== 128'd0 || busy2 !== 1'b0) begin errors++; $display("FAIL rst_mid got %h busy %b exp 0 0", dout2, busy2); end
        tick();
        checks++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL rst_mid_after got done %b busy %b exp 0 0", done2, busy2); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_relu();
        test_identity_partial();
        test_sigmoid();
        test_leaky();
        test_snapshot();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
